// File: rtl/camera_config_sequencer.sv
// SCCB write-only master: walks an external register table and programs the camera,
// one 3-byte write per entry, with delay and end markers; raises DONE after a full pass.
module camera_config_sequencer #(
    parameter int unsigned QUARTER = 125,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DELAY_Q = 4000,
    parameter logic [7:0]  DEV_ID  = 8'h42
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              START,
    output logic [ADDR_W-1:0] TABLE_ADDR,
    input  logic [15:0]       TABLE_DATA,
    output logic              SIOC,
    output logic              SIOD_OUT,
    output logic              SIOD_OE,
    output logic              BUSY,
    output logic              DONE
);
    typedef enum logic [3:0] {
        IDLE, FETCH, LATCH, START_C, BITS, STOP_C, GAP, DELAY, FINISH
    } state_t;

    localparam int unsigned QMAX = (DELAY_Q > 108) ? DELAY_Q : 108;
    localparam int unsigned CW   = $clog2(QUARTER);
    localparam int unsigned QW   = $clog2(QMAX);

    state_t              state, state_next;
    logic [CW-1:0]       cyc, cyc_next;
    logic [QW-1:0]       qtr, qtr_next;
    logic [26:0]         shift, shift_next;
    logic [ADDR_W-1:0]   addr_next;
    logic                qtr_end, advance, timed;
    logic [4:0]          bit_idx;
    logic                sioc_next, siod_next, oe_next, busy_next, done_next;

    assign qtr_end = (cyc == CW'(QUARTER - 1));
    assign timed   = state inside {START_C, BITS, STOP_C, GAP, DELAY};

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state      <= IDLE;
            cyc        <= '0;
            qtr        <= '0;
            shift      <= '0;
            TABLE_ADDR <= '0;
            SIOC       <= 1'b1;
            SIOD_OUT   <= 1'b1;
            SIOD_OE    <= 1'b1;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            state      <= state_next;
            cyc        <= cyc_next;
            qtr        <= qtr_next;
            shift      <= shift_next;
            TABLE_ADDR <= addr_next;
            SIOC       <= sioc_next;
            SIOD_OUT   <= siod_next;
            SIOD_OE    <= oe_next;
            BUSY       <= busy_next;
            DONE       <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        addr_next  = TABLE_ADDR;
        shift_next = shift;
        advance    = 1'b0;
        case (state)
            IDLE, FINISH: begin
                if (START) begin
                    state_next = FETCH;
                    addr_next  = '0;
                end
            end
            FETCH: state_next = LATCH;
            LATCH: begin
                if (TABLE_DATA == 16'hFFFF) begin
                    state_next = FINISH;
                end else if (TABLE_DATA == 16'hFFF0) begin
                    state_next = DELAY;
                end else begin
                    state_next = START_C;
                    // Ack slots are loaded as 1; the line is released there anyway.
                    shift_next = {DEV_ID, 1'b1, TABLE_DATA[15:8], 1'b1, TABLE_DATA[7:0], 1'b1};
                end
            end
            START_C: if (qtr_end && qtr == QW'(3))   state_next = BITS;
            BITS:    if (qtr_end && qtr == QW'(107)) state_next = STOP_C;
            STOP_C:  if (qtr_end && qtr == QW'(3))   state_next = GAP;
            GAP:     if (qtr_end && qtr == QW'(3))   advance = 1'b1;
            DELAY:   if (qtr_end && qtr == QW'(DELAY_Q - 1)) advance = 1'b1;
            default: state_next = IDLE;
        endcase
        // The last table slot never wraps back to address 0.
        if (advance) begin
            if (TABLE_ADDR == '1) begin
                state_next = FINISH;
            end else begin
                state_next = FETCH;
                addr_next  = TABLE_ADDR + ADDR_W'(1);
            end
        end
        if (state_next != state || !timed) begin
            cyc_next = '0;
            qtr_next = '0;
        end else if (qtr_end) begin
            cyc_next = '0;
            qtr_next = qtr + QW'(1);
        end else begin
            cyc_next = cyc + CW'(1);
            qtr_next = qtr;
        end
    end

    always_comb begin
        sioc_next = 1'b1;
        siod_next = 1'b1;
        oe_next   = 1'b1;
        bit_idx   = 5'(qtr_next >> 2);
        busy_next = !(state_next inside {IDLE, FINISH});
        done_next = (state_next == FINISH);
        case (state_next)
            START_C: begin
                sioc_next = ~qtr_next[1];
                siod_next = (qtr_next[1:0] == 2'd0);
            end
            BITS: begin
                sioc_next = qtr_next[1];
                if (bit_idx == 5'd8 || bit_idx == 5'd17 || bit_idx == 5'd26) begin
                    oe_next = 1'b0;
                end else begin
                    siod_next = shift_next[5'd26 - bit_idx];
                end
            end
            STOP_C: begin
                sioc_next = (qtr_next[1:0] != 2'd0);
                siod_next = qtr_next[1];
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_camera_config_sequencer.sv
// Bench for camera_config_sequencer: expands each table pass into the expected per-cycle
// bus waveform, compares every cycle, and sniffs the SCCB bytes for literal checks.
module tb_camera_config_sequencer;
    localparam int Q  = 2;
    localparam int DQ = 10;

    logic        clk = 1'b0;
    logic        RESET, START;
    logic [1:0]  table_addr;
    logic [15:0] table_data = '0;
    logic        SIOC, SIOD_OUT, SIOD_OE, BUSY, DONE;

    logic [15:0] rom [4];

    camera_config_sequencer #(
        .QUARTER(Q), .ADDR_W(2), .DELAY_Q(DQ), .DEV_ID(8'h42)
    ) dut (
        .CLOCK(clk), .RESET(RESET), .START(START),
        .TABLE_ADDR(table_addr), .TABLE_DATA(table_data),
        .SIOC(SIOC), .SIOD_OUT(SIOD_OUT), .SIOD_OE(SIOD_OE),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 clk = ~clk;
    always @(posedge clk) table_data <= rom[table_addr];

    typedef struct packed {
        logic c; logic d; logic oe; logic busy; logic done; logic [1:0] addr;
    } exp_t;

    exp_t        expq[$];
    exp_t        steady;
    int          checks = 0, errors = 0;
    bit          check_en = 0;
    int          ncount = 0;
    logic [7:0]  bytes[$], exp_bytes[$];
    int          starts[$];
    int          acks = 0, bitn = 0;
    logic [7:0]  acc = '0;
    logic        prev_sioc = 1'b1, prev_siod = 1'b1;
    int          edges;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input bit c, d, oe, busy, done, input int a);
        exp_t e;
        e.c = c; e.d = d; e.oe = oe; e.busy = busy; e.done = done; e.addr = 2'(a);
        return e;
    endfunction

    task automatic push_cycles(input bit c, d, oe, input int a, input int n);
        for (int i = 0; i < n; i++) expq.push_back(mk(c, d, oe, 1'b1, 1'b0, a));
    endtask

    // Expected waveform of one whole pass, starting the cycle after START is taken.
    task automatic build_pass();
        logic [15:0] w;
        logic [7:0]  b [3];
        logic [7:0]  cur;
        int          last;
        expq.delete();
        last = 3;
        for (int a = 0; a < 4; a++) begin
            w = rom[a];
            push_cycles(1, 1, 1, a, 2);
            if (w == 16'hFFFF) begin
                last = a;
                break;
            end
            if (w == 16'hFFF0) begin
                push_cycles(1, 1, 1, a, DQ * Q);
            end else begin
                push_cycles(1, 1, 1, a, Q); push_cycles(1, 0, 1, a, Q);
                push_cycles(0, 0, 1, a, 2 * Q);
                b[0] = 8'h42; b[1] = w[15:8]; b[2] = w[7:0];
                for (int k = 0; k < 3; k++) begin
                    cur = b[k];
                    for (int j = 7; j >= 0; j--) begin
                        push_cycles(0, cur[j], 1, a, 2 * Q);
                        push_cycles(1, cur[j], 1, a, 2 * Q);
                    end
                    push_cycles(0, 1, 0, a, 2 * Q);
                    push_cycles(1, 1, 0, a, 2 * Q);
                end
                push_cycles(0, 0, 1, a, Q); push_cycles(1, 0, 1, a, Q);
                push_cycles(1, 1, 1, a, 2 * Q);
                push_cycles(1, 1, 1, a, 4 * Q);
            end
        end
        steady = mk(1, 1, 1, 0, 1, last);
    endtask

    task automatic pulse_start(input bit fresh);
        @(negedge clk); #1;
        START = 1'b1;
        if (fresh) begin
            build_pass();
            bytes.delete(); starts.delete(); acks = 0; bitn = 0;
        end
        @(posedge clk); #1;
        START = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (DONE !== 1'b1 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic check_bytes(input int n_acks);
        check("byte count", bytes.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < bytes.size(); i++)
            check("byte value", bytes[i], exp_bytes[i]);
        check("ack slots", acks, n_acks);
    endtask

    task automatic check_reset_literals();
        check("reset SIOC", SIOC, 1'b1);
        check("reset SIOD_OUT", SIOD_OUT, 1'b1);
        check("reset SIOD_OE", SIOD_OE, 1'b1);
        check("reset BUSY", BUSY, 1'b0);
        check("reset DONE", DONE, 1'b0);
        check("reset TABLE_ADDR", table_addr, 2'd0);
    endtask

    initial begin : compare_proc
        exp_t e;
        forever begin
            @(negedge clk);
            ncount++;
            if (check_en) begin
                if (expq.size() > 0) e = expq.pop_front();
                else e = steady;
                check("SIOC", SIOC, e.c);
                check("SIOD_OE", SIOD_OE, e.oe);
                if (e.oe) check("SIOD_OUT", SIOD_OUT, e.d);
                check("BUSY", BUSY, e.busy);
                check("DONE", DONE, e.done);
                check("TABLE_ADDR", table_addr, e.addr);
                if (SIOC === 1'b1 && prev_sioc === 1'b0) begin
                    if (SIOD_OE === 1'b1) begin
                        acc = {acc[6:0], SIOD_OUT};
                        bitn++;
                        if (bitn == 8) begin
                            bytes.push_back(acc);
                            bitn = 0;
                        end
                    end else begin
                        acks++;
                    end
                end
                if (SIOC === 1'b1 && prev_sioc === 1'b1 && prev_siod === 1'b1 &&
                    SIOD_OUT === 1'b0 && SIOD_OE === 1'b1) begin
                    starts.push_back(ncount);
                    bitn = 0;
                end
                prev_sioc = SIOC;
                prev_siod = SIOD_OUT;
            end
        end
    end

    initial begin
        RESET = 1'b1;
        START = 1'b0;
        rom[0] = 16'h1280; rom[1] = 16'hFFFF; rom[2] = 16'h0000; rom[3] = 16'h0000;
        steady = mk(1, 1, 1, 0, 0, 0);
        @(posedge clk); #1;
        check_en = 1'b1;
        check_reset_literals();
        repeat (2) @(posedge clk);
        #1 RESET = 1'b0;
        repeat (3) @(posedge clk);

        // Single write followed by end marker.
        pulse_start(1);
        check("BUSY after START", BUSY, 1'b1);
        wait_done(edges);
        check("DONE latency single", edges, 244);
        exp_bytes = {8'h42, 8'h12, 8'h80};
        check_bytes(3);
        check("BUSY at DONE", BUSY, 1'b0);
        repeat (4) @(posedge clk);

        // Re-run from FINISH.
        pulse_start(1);
        check("DONE drops on restart", DONE, 1'b0);
        check("BUSY on restart", BUSY, 1'b1);
        check("addr on restart", table_addr, 2'd0);
        wait_done(edges);
        check("DONE latency rerun", edges, 244);
        check_bytes(3);
        repeat (4) @(posedge clk);

        // Delay marker between two writes.
        rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1104; rom[3] = 16'hFFFF;
        pulse_start(1);
        wait_done(edges);
        check("DONE latency delay", edges, 508);
        exp_bytes = {8'h42, 8'h12, 8'h80, 8'h42, 8'h11, 8'h04};
        check_bytes(6);
        check("start count delay", starts.size(), 2);
        if (starts.size() == 2) check("start spacing delay", starts[1] - starts[0], 264);
        check("final addr delay", table_addr, 2'd3);
        repeat (4) @(posedge clk);

        // START during a transaction is ignored.
        rom[0] = 16'h1280; rom[1] = 16'hFFFF; rom[2] = 16'h0000; rom[3] = 16'h0000;
        pulse_start(1);
        repeat (60) @(posedge clk);
        pulse_start(0);
        wait_done(edges);
        check("DONE latency ignored START", edges, 183);
        exp_bytes = {8'h42, 8'h12, 8'h80};
        check_bytes(3);
        repeat (4) @(posedge clk);

        // Reset while the register byte is on the wire, then a clean pass.
        pulse_start(1);
        repeat (100) @(posedge clk);
        @(negedge clk); #1;
        RESET = 1'b1;
        expq.delete();
        steady = mk(1, 1, 1, 0, 0, 0);
        @(posedge clk); #1;
        RESET = 1'b0;
        check_reset_literals();
        repeat (5) @(posedge clk);
        pulse_start(1);
        wait_done(edges);
        check("DONE latency after reset", edges, 244);
        check_bytes(3);
        repeat (4) @(posedge clk);

        // No end marker: four writes, then stop at the last address.
        rom[0] = 16'h1280; rom[1] = 16'h1104; rom[2] = 16'h3A0C; rom[3] = 16'h4001;
        pulse_start(1);
        wait_done(edges);
        check("DONE latency exhaust", edges, 968);
        exp_bytes = {8'h42, 8'h12, 8'h80, 8'h42, 8'h11, 8'h04,
                     8'h42, 8'h3A, 8'h0C, 8'h42, 8'h40, 8'h01};
        check_bytes(12);
        check("start count exhaust", starts.size(), 4);
        for (int i = 1; i < starts.size(); i++)
            check("start spacing exhaust", starts[i] - starts[i-1], 242);
        check("final addr exhaust", table_addr, 2'd3);
        repeat (300) @(posedge clk);
        check("no fifth write", starts.size(), 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
